aemb2_ctrl: RTL and testbench

AEMB2_CTRL -- requirements
Module: aemb2_ctrl

---
 rtl/aemb2_pkg.sv | 51 +++++
 rtl/aemb2_dwb_fsm.sv | 91 +++++++++
 rtl/aemb2_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_aemb2_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aemb2_pkg.sv
// aemb2_pkg: shared definitions for the AEMB2 pipeline control slice.
// Holds the opcode constants, the operand/ALU/writeback-source encodings and
// the data-bus FSM state type used by aemb2_ctrl and aemb2_dwb_fsm.
package aemb2_pkg;

  // Opcodes decoded by exact match (octal, as in the instruction set manual)
  localparam logic [5:0] OPC_BRU   = 6'o46;
  localparam logic [5:0] OPC_BRUI  = 6'o56;
  localparam logic [5:0] OPC_BCC   = 6'o47;
  localparam logic [5:0] OPC_BCCI  = 6'o57;
  localparam logic [5:0] OPC_RTD   = 6'o55;
  localparam logic [5:0] OPC_MOV   = 6'o45;
  localparam logic [5:0] OPC_SHIFT = 6'o44;
  localparam logic [5:0] OPC_MUL   = 6'o20;
  localparam logic [5:0] OPC_MULI  = 6'o30;
  localparam logic [5:0] OPC_BSF   = 6'o21;
  localparam logic [5:0] OPC_BSFI  = 6'o31;
  localparam logic [5:0] OPC_DIV   = 6'o22;

  // Operand source selects (mx_src / mx_tgt)
  localparam logic [1:0] MX_REG   = 2'd0;
  localparam logic [1:0] MX_FWD   = 2'd1;
  localparam logic [1:0] MX_RAM   = 2'd2;
  localparam logic [1:0] MX_PCIMM = 2'd3;

  // ALU function selects (mx_alu)
  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_LOGIC = 3'd1;
  localparam logic [2:0] ALU_SHIFT = 3'd2;
  localparam logic [2:0] ALU_MOVE  = 3'd3;
  localparam logic [2:0] ALU_MUL   = 3'd4;
  localparam logic [2:0] ALU_BSF   = 3'd5;
  localparam logic [2:0] ALU_DIV   = 3'd6;

  // Writeback source (mxdst): ALU result, link (PC), load data, or no write
  localparam logic [1:0] MXDST_ALU  = 2'd0;
  localparam logic [1:0] MXDST_LNK  = 2'd1;
  localparam logic [1:0] MXDST_RAM  = 2'd2;
  localparam logic [1:0] MXDST_NONE = 2'd3;

  // Interrupt exception code and the register that receives its return link
  localparam logic [1:0] XCE_INTR      = 2'd2;
  localparam int         INTR_LINK_REG = 14;

  typedef enum logic [1:0] {
    DWB_IDLE = 2'd0,
    DWB_BUS  = 2'd1,
    DWB_ERR  = 2'd2
  } dwbState_t;

endpackage

// File: rtl/aemb2_dwb_fsm.sv
// aemb2_dwb_fsm: data-bus handshake FSM with wait-state timeout.
// Ports:
//   gclk, grst  clock, async active-high reset
//   busStart    accept a new load/store this cycle
//   busStore    the access being started is a store
//   busAck      data-bus acknowledge
//   busStb      data-bus strobe (high for the whole access)
//   busWre      data-bus write enable
//   busStall    access in flight and not yet acknowledged
//   busErr      one-cycle timeout pulse
// Parameter TMO: wait cycles before timing out, 0 disables the timeout.
module aemb2_dwb_fsm
  import aemb2_pkg::*;
#(
  parameter int TMO = 15
) (
  input  logic gclk,
  input  logic grst,
  input  logic busStart,
  input  logic busStore,
  input  logic busAck,
  output logic busStb,
  output logic busWre,
  output logic busStall,
  output logic busErr
);

  localparam int            CW      = (TMO > 0) ? $clog2(TMO + 1) : 1;
  localparam logic [CW-1:0] TMO_LIM = CW'(TMO);

  dwbState_t     state, nextState;
  logic [CW-1:0] waitCnt, waitInc;
  logic          storeQ, accept, timeout;

  // The counter saturates at TMO; the timeout fires in the cycle whose
  // increment would reach TMO, so a TMO-cycle access times out after TMO
  // strobe cycles.
  always_comb begin
    waitInc = (waitCnt == TMO_LIM) ? waitCnt : waitCnt + CW'(1);
    timeout = (TMO != 0) && (waitInc == TMO_LIM);
  end

  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      state   <= DWB_IDLE;
      waitCnt <= '0;
      storeQ  <= 1'b0;
    end else begin
      state <= nextState;
      if (accept) begin
        waitCnt <= '0;
        storeQ  <= busStore;
      end else if (state == DWB_BUS) begin
        waitCnt <= waitInc;
      end
    end
  end

  // An ack always beats a coincident timeout; an ack together with a new
  // access keeps the bus busy for back-to-back transfers.
  always_comb begin
    nextState = state;
    accept    = 1'b0;
    case (state)
      DWB_IDLE: begin
        if (busStart) begin
          nextState = DWB_BUS;
          accept    = 1'b1;
        end
      end
      DWB_BUS: begin
        if (busAck) begin
          if (busStart) accept = 1'b1;
          else nextState = DWB_IDLE;
        end else if (timeout) begin
          nextState = DWB_ERR;
        end
      end
      DWB_ERR:  nextState = DWB_IDLE;
      default:  nextState = DWB_IDLE;
    endcase
  end

  always_comb begin
    busStb   = (state == DWB_BUS);
    busWre   = (state == DWB_BUS) && storeQ;
    busStall = (state == DWB_BUS) && !busAck;
    busErr   = (state == DWB_ERR);
  end

endmodule

// File: rtl/aemb2_ctrl.sv
// aemb2_ctrl: AEMB2 decode-stage control -- ALU select, writeback tracking,
// operand forwarding / hazard stall and data-bus control.
// Ports:
//   gclk, grst              clock, async active-high reset
//   gena                    pipeline advance enable
//   dec_opc, dec_rd/ra/rb   current decode
//   br_take, br_dly         branch taken / taken branch has a delay slot
//   xce                     exception code (2 = interrupt)
//   dwb_ack_i               data-bus acknowledge
//   mx_src, mx_tgt, fwd_sel operand selects and forwarded stage index
//   mx_alu                  ALU function select
//   wb_rw, wb_mxdst         writeback register and source (entry 0)
//   dwb_stb_o, dwb_wre_o    data-bus strobe / write enable
//   stall_o                 freeze upstream pipeline
//   bus_err_o               one-cycle bus-timeout pulse
// Build option: define AEMB2_CTRL_FWD_EN to forward results from the
// writeback stages; otherwise any dependency stalls until it has retired.
module aemb2_ctrl
  import aemb2_pkg::*;
#(
  parameter int RW        = 5,
  parameter int FWD_DEPTH = 2,
  parameter int TMO       = 15
) (
  input  logic          gclk,
  input  logic          grst,
  input  logic          gena,
  input  logic [5:0]    dec_opc,
  input  logic [RW-1:0] dec_rd,
  input  logic [RW-1:0] dec_ra,
  input  logic [RW-1:0] dec_rb,
  input  logic          br_take,
  input  logic          br_dly,
  input  logic [1:0]    xce,
  input  logic          dwb_ack_i,
  output logic [1:0]    mx_src,
  output logic [1:0]    mx_tgt,
  output logic [1:0]    fwd_sel,
  output logic [2:0]    mx_alu,
  output logic [RW-1:0] wb_rw,
  output logic [1:0]    wb_mxdst,
  output logic          dwb_stb_o,
  output logic          dwb_wre_o,
  output logic          stall_o,
  output logic          bus_err_o
);

  logic [RW-1:0]        wbRwQ [FWD_DEPTH];
  logic [1:0]           wbMxQ [FWD_DEPTH];
  logic                 isLoad, isStore, isBranch, isBrUncond, isBrCond;
  logic                 isReturn, isMove, isShift, isLogic, isMul, isBsf, isDiv;
  logic                 isSkip, useA, useB, hazard, advance, busStart;
  logic                 busStall, busErr;
  logic [FWD_DEPTH-1:0] hitA, hitB;
  logic [RW-1:0]        nextRw;
  logic [1:0]           nextMx;

  always_comb begin
    isLoad     = (dec_opc[5:4] == 2'b11) && !dec_opc[2];
    isStore    = (dec_opc[5:4] == 2'b11) && dec_opc[2];
    isBrUncond = (dec_opc == OPC_BRU) || (dec_opc == OPC_BRUI);
    isBrCond   = (dec_opc == OPC_BCC) || (dec_opc == OPC_BCCI);
    isBranch   = isBrUncond || isBrCond;
    isReturn   = (dec_opc == OPC_RTD);
    isMove     = (dec_opc == OPC_MOV);
    isShift    = (dec_opc == OPC_SHIFT);
    isLogic    = (dec_opc[5:4] == 2'b10) && dec_opc[2];
    isMul      = (dec_opc == OPC_MUL) || (dec_opc == OPC_MULI);
    isBsf      = (dec_opc == OPC_BSF) || (dec_opc == OPC_BSFI);
    isDiv      = (dec_opc == OPC_DIV);
    isSkip     = br_take && !br_dly;
  end

  // The logic group overlaps several exact opcodes, so the order matters.
  always_comb begin
    if (isMove || (isBrUncond && dec_ra[3])) mx_alu = ALU_MOVE;
    else if (isShift) mx_alu = ALU_SHIFT;
    else if (isLogic) mx_alu = ALU_LOGIC;
    else if (isMul)   mx_alu = ALU_MUL;
    else if (isBsf)   mx_alu = ALU_BSF;
    else if (isDiv)   mx_alu = ALU_DIV;
    else              mx_alu = ALU_ADD;
  end

  // r0 is hard-wired zero, so a pending write to it is never a dependency.
  always_comb begin
    hitA = '0;
    hitB = '0;
    for (int k = 0; k < FWD_DEPTH; k++) begin
      hitA[k] = (wbRwQ[k] == dec_ra) && (wbRwQ[k] != '0);
      hitB[k] = (wbRwQ[k] == dec_rb) && (wbRwQ[k] != '0);
    end
    useA = (|hitA) && !isBranch;
    useB = (|hitB) && !dec_opc[3];
  end

`ifdef AEMB2_CTRL_FWD_EN
  logic [1:0] selA, selB;
  logic       ramA, ramB;

  // Scan from the oldest entry down so the youngest matching result wins.
  always_comb begin
    selA = 2'd0;
    selB = 2'd0;
    ramA = 1'b0;
    ramB = 1'b0;
    for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
      if (hitA[k]) begin
        selA = 2'(k);
        ramA = (wbMxQ[k] == MXDST_RAM);
      end
      if (hitB[k]) begin
        selB = 2'(k);
        ramB = (wbMxQ[k] == MXDST_RAM);
      end
    end
  end

  always_comb begin
    if (isBranch)  mx_src = MX_PCIMM;
    else if (useA) mx_src = ramA ? MX_RAM : MX_FWD;
    else           mx_src = MX_REG;
    if (dec_opc[3]) mx_tgt = MX_PCIMM;
    else if (useB)  mx_tgt = ramB ? MX_RAM : MX_FWD;
    else            mx_tgt = MX_REG;
    if (useA)      fwd_sel = selA;
    else if (useB) fwd_sel = selB;
    else           fwd_sel = 2'd0;
    hazard = 1'b0;
  end
`else
  always_comb begin
    mx_src  = isBranch ? MX_PCIMM : MX_REG;
    mx_tgt  = dec_opc[3] ? MX_PCIMM : MX_REG;
    fwd_sel = 2'd0;
    hazard  = useA || useB;
  end
`endif

  // A hazard freezes upstream but the writeback pipe keeps moving with
  // bubbles so the dependency eventually drains; only a bus wait holds it.
  always_comb begin
    advance  = gena && !busStall;
    busStart = (isLoad || isStore) && !isSkip && (xce == 2'd0) && gena && !hazard;
    stall_o  = busStall || hazard;
  end

  always_comb begin
    nextRw = dec_rd;
    nextMx = MXDST_ALU;
    if (isStore || isReturn || isBrCond) nextMx = MXDST_NONE;
    else if (isLoad)                     nextMx = MXDST_RAM;
    else if (isBrUncond)                 nextMx = MXDST_LNK;
    if (isSkip) begin
      nextRw = '0;
      nextMx = MXDST_ALU;
    end else if (xce == XCE_INTR) begin
      nextRw = RW'(INTR_LINK_REG);
      nextMx = MXDST_LNK;
    end
    if (hazard) begin
      nextRw = '0;
      nextMx = MXDST_ALU;
    end
    if (busErr) nextRw = '0;
  end

  // A failed load must not write its destination, so the error cycle
  // clears entry 0 even when the pipe is not advancing.
  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      for (int k = 0; k < FWD_DEPTH; k++) begin
        wbRwQ[k] <= '0;
        wbMxQ[k] <= '0;
      end
    end else if (advance) begin
      for (int k = FWD_DEPTH - 1; k > 0; k--) begin
        wbRwQ[k] <= wbRwQ[k-1];
        wbMxQ[k] <= wbMxQ[k-1];
      end
      wbRwQ[0] <= nextRw;
      wbMxQ[0] <= nextMx;
    end else if (busErr) begin
      wbRwQ[0] <= '0;
    end
  end

  assign wb_rw     = wbRwQ[0];
  assign wb_mxdst  = wbMxQ[0];
  assign bus_err_o = busErr;

  aemb2_dwb_fsm #(.TMO(TMO)) uDwbFsm (
    .gclk     (gclk),
    .grst     (grst),
    .busStart (busStart),
    .busStore (isStore),
    .busAck   (dwb_ack_i),
    .busStb   (dwb_stb_o),
    .busWre   (dwb_wre_o),
    .busStall (busStall),
    .busErr   (busErr)
  );

endmodule

// File: tb/tb_aemb2_ctrl.sv
// tb_aemb2_ctrl: directed bench for aemb2_ctrl (TMO = 4, FWD_DEPTH = 2).
// Expectations follow the AEMB2_CTRL_FWD_EN build option of the design.
module tb_aemb2_ctrl;

  localparam int RW        = 5;
  localparam int FWD_DEPTH = 2;
  localparam int TMO       = 4;

  logic          gclk, grst, gena, br_take, br_dly, dwb_ack_i;
  logic [5:0]    dec_opc;
  logic [RW-1:0] dec_rd, dec_ra, dec_rb;
  logic [1:0]    xce;
  logic [1:0]    mx_src, mx_tgt, fwd_sel, wb_mxdst;
  logic [2:0]    mx_alu;
  logic [RW-1:0] wb_rw;
  logic          dwb_stb_o, dwb_wre_o, stall_o, bus_err_o;

  int nVec = 0;
  int nErr = 0;

  typedef struct {
    logic [5:0] opc;
    logic [4:0] ra;
    logic [2:0] alu;
    logic [1:0] src;
    logic [1:0] tgt;
  } vec_t;

  vec_t vecs [16];

  aemb2_ctrl #(.RW(RW), .FWD_DEPTH(FWD_DEPTH), .TMO(TMO)) dut (
    .gclk      (gclk),
    .grst      (grst),
    .gena      (gena),
    .dec_opc   (dec_opc),
    .dec_rd    (dec_rd),
    .dec_ra    (dec_ra),
    .dec_rb    (dec_rb),
    .br_take   (br_take),
    .br_dly    (br_dly),
    .xce       (xce),
    .dwb_ack_i (dwb_ack_i),
    .mx_src    (mx_src),
    .mx_tgt    (mx_tgt),
    .fwd_sel   (fwd_sel),
    .mx_alu    (mx_alu),
    .wb_rw     (wb_rw),
    .wb_mxdst  (wb_mxdst),
    .dwb_stb_o (dwb_stb_o),
    .dwb_wre_o (dwb_wre_o),
    .stall_o   (stall_o),
    .bus_err_o (bus_err_o)
  );

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  task automatic applyStimulus(input logic [5:0] opc, input logic [4:0] rd,
                               input logic [4:0] ra, input logic [4:0] rb,
                               input logic take, input logic dly,
                               input logic [1:0] x, input logic en,
                               input logic ack);
    dec_opc   = opc;
    dec_rd    = rd;
    dec_ra    = ra;
    dec_rb    = rb;
    br_take   = take;
    br_dly    = dly;
    xce       = x;
    gena      = en;
    dwb_ack_i = ack;
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    nVec++;
    if (actual != expected) begin
      nErr++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge gclk);
    #1;
  endtask

  task automatic doReset();
    grst = 1'b1;
    applyStimulus(6'o00, 0, 0, 0, 0, 0, 2'd0, 0, 0);
    step();
    grst = 1'b0;
    step();
  endtask

  initial begin
    int stbCnt, stallCnt, wreCnt, errCnt, srcBad;

    grst = 1'b1;
    applyStimulus(6'o00, 0, 0, 0, 0, 0, 2'd0, 0, 0);

    vecs[0]  = '{6'o45, 5'd0, 3'd3, 2'd0, 2'd0};
    vecs[1]  = '{6'o46, 5'd8, 3'd3, 2'd3, 2'd0};
    vecs[2]  = '{6'o46, 5'd0, 3'd1, 2'd3, 2'd0};
    vecs[3]  = '{6'o56, 5'd8, 3'd3, 2'd3, 2'd3};
    vecs[4]  = '{6'o47, 5'd8, 3'd1, 2'd3, 2'd0};
    vecs[5]  = '{6'o44, 5'd0, 3'd2, 2'd0, 2'd0};
    vecs[6]  = '{6'o54, 5'd0, 3'd1, 2'd0, 2'd3};
    vecs[7]  = '{6'o20, 5'd0, 3'd4, 2'd0, 2'd0};
    vecs[8]  = '{6'o30, 5'd0, 3'd4, 2'd0, 2'd3};
    vecs[9]  = '{6'o21, 5'd0, 3'd5, 2'd0, 2'd0};
    vecs[10] = '{6'o31, 5'd0, 3'd5, 2'd0, 2'd3};
    vecs[11] = '{6'o22, 5'd0, 3'd6, 2'd0, 2'd0};
    vecs[12] = '{6'o00, 5'd0, 3'd0, 2'd0, 2'd0};
    vecs[13] = '{6'o10, 5'd0, 3'd0, 2'd0, 2'd3};
    vecs[14] = '{6'o55, 5'd0, 3'd1, 2'd0, 2'd3};
    vecs[15] = '{6'o62, 5'd0, 3'd0, 2'd0, 2'd0};

    // Reset state
    repeat (2) step();
    checkOutput("rst_stb", dwb_stb_o, 0);
    checkOutput("rst_wre", dwb_wre_o, 0);
    checkOutput("rst_stall", stall_o, 0);
    checkOutput("rst_err", bus_err_o, 0);
    checkOutput("rst_wb_rw", wb_rw, 0);
    checkOutput("rst_wb_mxdst", wb_mxdst, 0);
    grst = 1'b0;
    step();

    // Decode table with an empty writeback pipe and the pipe held
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].opc, 0, vecs[i].ra, 0, 0, 0, 2'd0, 0, 0);
      checkOutput($sformatf("vec%0d_alu", i), mx_alu, vecs[i].alu);
      checkOutput($sformatf("vec%0d_src", i), mx_src, vecs[i].src);
      checkOutput($sformatf("vec%0d_tgt", i), mx_tgt, vecs[i].tgt);
      checkOutput($sformatf("vec%0d_stall", i), stall_o, 0);
    end

    // Load r3, ack in the third bus cycle
    doReset();
    applyStimulus(6'o62, 3, 0, 0, 0, 0, 2'd0, 1, 0);
    step();
    checkOutput("ld_wb_rw", wb_rw, 3);
    checkOutput("ld_wb_mxdst", wb_mxdst, 2);
    stbCnt = 0; stallCnt = 0; wreCnt = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(6'o00, 0, 0, 0, 0, 0, 2'd0, 1, (i == 2));
      stbCnt   += int'(dwb_stb_o);
      stallCnt += int'(stall_o);
      wreCnt   += int'(dwb_wre_o);
      step();
    end
    checkOutput("ld_stb_cycles", stbCnt, 3);
    checkOutput("ld_stall_cycles", stallCnt, 2);
    checkOutput("ld_wre_cycles", wreCnt, 0);

    // Back-to-back: ack together with a new store keeps the bus busy
    doReset();
    applyStimulus(6'o62, 3, 0, 0, 0, 0, 2'd0, 1, 0);
    step();
    applyStimulus(6'o66, 4, 0, 0, 0, 0, 2'd0, 1, 1);
    checkOutput("b2b_stall", stall_o, 0);
    step();
    checkOutput("b2b_stb", dwb_stb_o, 1);
    checkOutput("b2b_wre", dwb_wre_o, 1);
    checkOutput("b2b_wb_rw", wb_rw, 4);
    checkOutput("b2b_wb_mxdst", wb_mxdst, 3);
    applyStimulus(6'o00, 0, 0, 0, 0, 0, 2'd0, 1, 1);
    step();
    checkOutput("b2b_stb_end", dwb_stb_o, 0);

    // Ack arriving in the cycle the timeout is reached wins
    doReset();
    applyStimulus(6'o62, 3, 0, 0, 0, 0, 2'd0, 1, 0);
    step();
    stbCnt = 0; errCnt = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(6'o00, 7, 0, 0, 0, 0, 2'd0, 0, (i == 3));
      stbCnt += int'(dwb_stb_o);
      errCnt += int'(bus_err_o);
      step();
    end
    checkOutput("ackto_stb_cycles", stbCnt, 4);
    checkOutput("ackto_err_cycles", errCnt, 0);
    checkOutput("ackto_wb_rw", wb_rw, 3);

    // Timeout with no ack
    doReset();
    applyStimulus(6'o62, 3, 0, 0, 0, 0, 2'd0, 1, 0);
    step();
    checkOutput("tmo_wb_rw_issue", wb_rw, 3);
    stbCnt = 0; errCnt = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(6'o00, 7, 0, 0, 0, 0, 2'd0, 0, 0);
      stbCnt += int'(dwb_stb_o);
      errCnt += int'(bus_err_o);
      step();
    end
    checkOutput("tmo_stb_cycles", stbCnt, 4);
    checkOutput("tmo_err_pulses", errCnt, 1);
    checkOutput("tmo_wb_rw", wb_rw, 0);

    // Skipped store, then a store in a delay slot
    doReset();
    applyStimulus(6'o66, 9, 0, 0, 1, 0, 2'd0, 1, 0);
    step();
    checkOutput("skip_stb", dwb_stb_o, 0);
    checkOutput("skip_wb_rw", wb_rw, 0);
    checkOutput("skip_wb_mxdst", wb_mxdst, 0);
    applyStimulus(6'o66, 9, 0, 0, 1, 1, 2'd0, 1, 0);
    step();
    checkOutput("dly_stb", dwb_stb_o, 1);
    checkOutput("dly_wre", dwb_wre_o, 1);
    checkOutput("dly_wb_rw", wb_rw, 9);
    checkOutput("dly_wb_mxdst", wb_mxdst, 3);
    applyStimulus(6'o00, 0, 0, 0, 0, 0, 2'd0, 1, 1);
    step();
    checkOutput("dly_stb_end", dwb_stb_o, 0);

    // Interrupt on a load: link to r14, no bus access
    doReset();
    applyStimulus(6'o62, 3, 0, 0, 0, 0, 2'd2, 1, 0);
    step();
    checkOutput("intr_wb_rw", wb_rw, 14);
    checkOutput("intr_wb_mxdst", wb_mxdst, 1);
    checkOutput("intr_stb", dwb_stb_o, 0);

    // Dependency on r5 written by the previous instruction
    doReset();
    applyStimulus(6'o00, 5, 1, 2, 0, 0, 2'd0, 1, 0);
    step();
`ifdef AEMB2_CTRL_FWD_EN
    applyStimulus(6'o00, 6, 5, 0, 0, 0, 2'd0, 0, 0);
    checkOutput("fwd_src", mx_src, 1);
    checkOutput("fwd_sel", fwd_sel, 0);
    checkOutput("fwd_stall", stall_o, 0);
    applyStimulus(6'o00, 6, 0, 0, 0, 0, 2'd0, 0, 0);
    checkOutput("fwd_r0_src", mx_src, 0);
    applyStimulus(6'o00, 6, 1, 2, 0, 0, 2'd0, 1, 0);
    step();
    applyStimulus(6'o00, 0, 5, 6, 0, 0, 2'd0, 0, 0);
    checkOutput("fwd_ab_src", mx_src, 1);
    checkOutput("fwd_ab_tgt", mx_tgt, 1);
    checkOutput("fwd_ab_sel", fwd_sel, 1);
    applyStimulus(6'o00, 0, 0, 5, 0, 0, 2'd0, 0, 0);
    checkOutput("fwd_b_tgt", mx_tgt, 1);
    checkOutput("fwd_b_sel", fwd_sel, 1);
    applyStimulus(6'o10, 0, 0, 5, 0, 0, 2'd0, 0, 0);
    checkOutput("fwd_imm_tgt", mx_tgt, 3);
    checkOutput("fwd_imm_sel", fwd_sel, 0);
`else
    applyStimulus(6'o00, 6, 5, 0, 0, 0, 2'd0, 1, 0);
    stallCnt = 0; srcBad = 0;
    for (int i = 0; i < 5; i++) begin
      stallCnt += int'(stall_o);
      srcBad   += int'(mx_src != 2'd0) + int'(fwd_sel != 2'd0);
      step();
    end
    checkOutput("haz_stall_cycles", stallCnt, FWD_DEPTH);
    checkOutput("haz_src_fwd_nonzero", srcBad, 0);
    checkOutput("haz_wb_rw", wb_rw, 6);
`endif

    // Dependency on a load result still in entry 0
    doReset();
    applyStimulus(6'o62, 3, 0, 0, 0, 0, 2'd0, 1, 0);
    step();
    applyStimulus(6'o00, 0, 3, 0, 0, 0, 2'd0, 0, 1);
`ifdef AEMB2_CTRL_FWD_EN
    checkOutput("ldfwd_src", mx_src, 2);
    checkOutput("ldfwd_sel", fwd_sel, 0);
    checkOutput("ldfwd_stall", stall_o, 0);
`else
    checkOutput("ldhaz_src", mx_src, 0);
    checkOutput("ldhaz_stall", stall_o, 1);
`endif
    step();

    // Reset asserted mid-access drops the strobe immediately
    doReset();
    applyStimulus(6'o62, 3, 0, 0, 0, 0, 2'd0, 1, 0);
    step();
    applyStimulus(6'o00, 0, 0, 0, 0, 0, 2'd0, 0, 0);
    checkOutput("midrst_stb_before", dwb_stb_o, 1);
    grst = 1'b1;
    #1;
    checkOutput("midrst_stb", dwb_stb_o, 0);
    checkOutput("midrst_stall", stall_o, 0);
    checkOutput("midrst_wb_rw", wb_rw, 0);
    step();
    grst = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
